// File: rtl/fractal_sync_cam_ctrl.sv
// fractal_sync_cam_ctrl: per-port request scheduler in front of the
// fractal-sync multi-port CAM. Each requester port owns a small
// IDLE/PEND/RESP FSM. A round-robin grant stage decides which pending
// ports may issue a CAM check this cycle. It suppresses same-cycle
// duplicate signatures and stores that would overflow the CAM.
// Optional statistics counters: define FRACTAL_SYNC_CAM_CTRL_STATS_EN.
module fractal_sync_cam_ctrl #(
  parameter  int unsigned N_PORTS   = 2,
  parameter  int unsigned N_LINES   = 1,
  parameter  int unsigned SIG_WIDTH = 1,
  localparam int unsigned OCC_W     = $clog2(N_LINES + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [N_PORTS-1:0]                 req_valid_i,
  output logic [N_PORTS-1:0]                 req_ready_o,
  input  logic [N_PORTS-1:0][SIG_WIDTH-1:0]  req_sig_i,
  output logic [N_PORTS-1:0]                 rsp_valid_o,
  input  logic [N_PORTS-1:0]                 rsp_ready_i,
  output logic [N_PORTS-1:0]                 rsp_hit_o,
  output logic [N_PORTS-1:0]                 cam_check_o,
  output logic [N_PORTS-1:0]                 cam_set_o,
  output logic [N_PORTS-1:0][SIG_WIDTH-1:0]  cam_sig_o,
  output logic [N_PORTS-1:0]                 cam_sig_valid_o,
  input  logic [N_PORTS-1:0]                 cam_present_i,
  output logic [OCC_W-1:0]                   occupancy_o
`ifdef FRACTAL_SYNC_CAM_CTRL_STATS_EN
  ,
  output logic [31:0]                        stat_hits_o,
  output logic [31:0]                        stat_stores_o,
  output logic [31:0]                        stat_stall_cycles_o
`endif
);

  localparam int unsigned RR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(N_PORTS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_RESP
  } state_e;

  state_e                            r_state [N_PORTS];
  logic [N_PORTS-1:0][SIG_WIDTH-1:0] r_sig;
  logic [N_PORTS-1:0]                r_hit;
  logic [RR_W-1:0]                   r_rr;
  logic [OCC_W-1:0]                  r_occ;

  logic [N_PORTS-1:0]                w_pend;
  logic [N_PORTS-1:0]                w_grant;
  logic [RR_W-1:0]                   w_rr_next;
  logic [CNT_W-1:0]                  w_n_store;
  logic [CNT_W-1:0]                  w_n_hit;
  logic [OCC_W-1:0]                  w_occ_next;

  // Decode per-port state into handshake and CAM request outputs.
  always_comb begin
    w_pend          = '0;
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    cam_sig_valid_o = '0;
    cam_sig_o       = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      w_pend[p]          = (r_state[p] == ST_PEND);
      req_ready_o[p]     = (r_state[p] == ST_IDLE);
      rsp_valid_o[p]     = (r_state[p] == ST_RESP);
      cam_sig_valid_o[p] = w_pend[p];
      cam_sig_o[p]       = w_pend[p] ? r_sig[p] : '0;
    end
  end

  // Round-robin grant: hits always pass unless duplicated. Stores pass only
  // while lines remain. A line freed by a hit is not reused until next cycle.
  // Duplicate detection compares against every earlier pending port (not only
  // granted ones). Same signature implies same present, so the first holder
  // decides the outcome for the whole group.
  always_comb begin
    logic [31:0] v_store;
    logic [31:0] v_hit;
    logic        v_dup;
    int unsigned v_p;
    int unsigned v_q;
    v_store   = '0;
    v_hit     = '0;
    v_dup     = 1'b0;
    v_p       = 0;
    v_q       = 0;
    w_grant   = '0;
    w_rr_next = r_rr;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      v_p   = (32'(r_rr) + k) % N_PORTS;
      v_dup = 1'b0;
      for (int unsigned j = 0; j < k; j++) begin
        v_q = (32'(r_rr) + j) % N_PORTS;
        if (w_pend[v_q] && (r_sig[v_q] == r_sig[v_p])) v_dup = 1'b1;
      end
      if (w_pend[v_p] && !v_dup) begin
        if (cam_present_i[v_p]) begin
          w_grant[v_p] = 1'b1;
          v_hit        = v_hit + 32'd1;
        end else if ((32'(r_occ) + v_store) < N_LINES) begin
          w_grant[v_p] = 1'b1;
          v_store      = v_store + 32'd1;
        end
      end
      if (w_grant[v_p]) w_rr_next = RR_W'((v_p + 1) % N_PORTS);
    end
    w_n_store = CNT_W'(v_store);
    w_n_hit   = CNT_W'(v_hit);
  end

  assign w_occ_next  = OCC_W'(32'(r_occ) + 32'(w_n_store) - 32'(w_n_hit));
  assign cam_check_o = w_grant;
  assign cam_set_o   = '0;
  assign rsp_hit_o   = r_hit;
  assign occupancy_o = r_occ;

  // Port FSMs, round-robin pointer and CAM occupancy tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        r_state[p] <= ST_IDLE;
      end
      r_sig <= '0;
      r_hit <= '0;
      r_rr  <= '0;
      r_occ <= '0;
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        case (r_state[p])
          ST_IDLE: begin
            if (req_valid_i[p]) begin
              r_sig[p]   <= req_sig_i[p];
              r_state[p] <= ST_PEND;
            end
          end
          ST_PEND: begin
            if (w_grant[p]) begin
              r_hit[p]   <= cam_present_i[p];
              r_state[p] <= ST_RESP;
            end
          end
          ST_RESP: begin
            if (rsp_ready_i[p]) r_state[p] <= ST_IDLE;
          end
          default: r_state[p] <= ST_IDLE;
        endcase
      end
      r_rr  <= w_rr_next;
      r_occ <= w_occ_next;
    end
  end

`ifndef SYNTHESIS
  // Occupancy must stay within the CAM and never underflow.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (32'(r_occ) <= N_LINES);
      assert ((32'(r_occ) + 32'(w_n_store)) >= 32'(w_n_hit));
    end
  end
`endif

`ifdef FRACTAL_SYNC_CAM_CTRL_STATS_EN
  logic        w_stall;
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_stores;
  logic [31:0] r_stat_stall;

  assign w_stall = |(w_pend & ~w_grant);

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // Saturating event counters for granted hits, stores and stall cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_hits   <= '0;
      r_stat_stores <= '0;
      r_stat_stall  <= '0;
    end else begin
      r_stat_hits   <= sat_add(r_stat_hits, 32'(w_n_hit));
      r_stat_stores <= sat_add(r_stat_stores, 32'(w_n_store));
      r_stat_stall  <= sat_add(r_stat_stall, {31'b0, w_stall});
    end
  end

  assign stat_hits_o         = r_stat_hits;
  assign stat_stores_o       = r_stat_stores;
  assign stat_stall_cycles_o = r_stat_stall;
`endif

endmodule

// File: doc/fractal_sync_cam_ctrl.md
Name: fractal_sync_cam_ctrl

Overview:
- Per-port request scheduler in front of the fractal-sync multi-port CAM (check/set/sig/sig_valid/present interface).
- Accepts barrier-arrival requests (signatures) from N_PORTS requesters over valid/ready and decides which ports may issue a CAM check each cycle.
- Prevents same-cycle duplicate-signature stores and CAM overflow, and returns a per-port hit/stored response.

Parameters:
- N_PORTS, 2, number of requester ports (= CAM ports)
- N_LINES, 1, CAM line count; must be >= 1
- SIG_WIDTH, 1, signature width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i[N_PORTS]  in  1  request valid
- req_ready_o[N_PORTS]  out  1  request ready
- req_sig_i[N_PORTS]  in  SIG_WIDTH  request signature
- rsp_valid_o[N_PORTS]  out  1  response valid
- rsp_ready_i[N_PORTS]  in  1  response ready
- rsp_hit_o[N_PORTS]  out  1  1 = signature was present (barrier complete, line freed); 0 = signature stored
- cam_check_o[N_PORTS]  out  1  to CAM check_i
- cam_set_o[N_PORTS]  out  1  to CAM set_i, tied 0
- cam_sig_o[N_PORTS]  out  SIG_WIDTH  to CAM sig_i
- cam_sig_valid_o[N_PORTS]  out  1  to CAM sig_valid_i
- cam_present_i[N_PORTS]  in  1  from CAM present_o (combinational in same cycle)
- occupancy_o  out  $clog2(N_LINES+1)  CAM lines in use

Behaviour:
- Reset: all port FSMs IDLE; req_ready_o=1, rsp_valid_o=0, rsp_hit_o=0, cam_* outputs 0, occupancy_o=0, rr_ptr=0, signature regs 0. The CAM shares the reset, so state stays consistent if reset is asserted mid-operation; any in-flight request is dropped.
- Per-port FSM:
  - IDLE: req_ready_o=1. On req_valid_i & req_ready_o, latch req_sig_i and go to PEND.
  - PEND: cam_sig_o = latched sig, cam_sig_valid_o=1, req_ready_o=0. When granted, cam_check_o=1 for exactly this cycle, rsp_hit_o <= cam_present_i, go to RESP. Otherwise stay in PEND.
  - RESP: rsp_valid_o=1, held stable until rsp_ready_i, then go to IDLE. A new request cannot be accepted in the same cycle as the response handshake.
- Minimum latency: request accepted at edge E0; check issued in cycle after E0; rsp_valid_o visible after E1. 2 cycles total.
- Grant rules, evaluated each cycle over PEND ports in round-robin order starting at rr_ptr:
  - Hit port (present=1): granted, subject to the duplicate rule only.
  - Store port (present=0): granted only if occupancy + stores already granted this cycle < N_LINES.
  - Duplicate rule: at most one port per distinct signature is granted per cycle, namely the first in rr order. The losers retry next cycle and will then see present.
  - Granted ports never exceed one CAM write per store, so the CAM's internal line allocation never fails.
- rr_ptr: when >=1 grant occurs, next rr_ptr = (last granted port in rr order + 1) mod N_PORTS; otherwise unchanged.
- Occupancy: occ_next = occ + (#granted stores) - (#granted hits), updated in the same edge. Simultaneous stores and hits are both counted. The free from a hit is not reusable by a store in the same cycle; it becomes available next cycle.
- Invariant (assertion, non-synthesis): occupancy <= N_LINES; no underflow.
- When occupancy == N_LINES: store ports stall; hit ports proceed.

Optional Feature:
FRACTAL_SYNC_CAM_CTRL_STATS_EN:
- Defined: adds outputs stat_hits_o, stat_stores_o, stat_stall_cycles_o, each 32 bit, saturating, reset to 0.
  - stat_hits_o / stat_stores_o: count granted hits / stores.
  - stat_stall_cycles_o: counts cycles in which >=1 PEND port was not granted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single arrival: N_PORTS=2, N_LINES=1. Port0 sends sig 0x5, present=0 -> cam_check_o[0] one cycle; rsp_valid_o[0] 2 cycles after accept, rsp_hit_o=0; occupancy 1.
- Pairing: after the above, port1 sends 0x5, present=1 -> rsp_hit_o[1]=1; occupancy returns to 0.
- Same-cycle duplicate: ports 0 and 1 send 0x3 together, rr_ptr=0 -> port0 stored in cycle 1 (hit=0); port1 checks in cycle 2 with hit=1; occupancy 0 -> 1 -> 0.
- Capacity full: N_LINES=1 holding 0x1; port0 requests 0x2 -> stalls in PEND, no cam_check_o. Port1 then requests 0x1 -> hit, occupancy 0; port0 issues the following cycle (stored, occupancy 1).
- Back-pressure: rsp_ready_i[0]=0 for 5 cycles -> rsp_valid_o/rsp_hit_o held stable, req_ready_o[0]=0. Release -> IDLE next cycle.
- Reset mid-PEND: assert rst_ni=0 with port0 in PEND -> all outputs reset immediately (asynchronous); after release, occupancy 0 and new requests behave as the single-arrival case.
